// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands the single UART transmit path to one client at a time.
// A grant covers one frame (or MAX_BURST bytes) and is held until the UART has drained it.
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int FIFO_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int MAX_BURST    = 8,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*FIFO_WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            grant,
    output logic                       wen,
    output logic [FIFO_WIDTH-1:0]      wr_data,
    input  logic                       tx_full,
    input  logic                       tx_empty,
    input  logic                       tx_done,
    output logic                       tx_begin,
    output logic                       busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    // A burst can never exceed what the UART FIFO holds while it waits for tx_begin.
    localparam int BURST_LIMIT = (MAX_BURST < FIFO_DEPTH) ? MAX_BURST : FIFO_DEPTH;

    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LIMIT - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_XFER  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]            state;
    logic [PW-1:0]         rr_ptr;
    logic [BW-1:0]         burst_cnt;
    logic [IW-1:0]         idle_cnt;

    logic                  pick_found;
    logic [PW-1:0]         pick_idx;
    int                    cand;
    logic [PW-1:0]         g_idx;
    logic                  g_valid;
    logic                  g_last;
    logic [FIFO_WIDTH-1:0] g_data;
    logic [PW-1:0]         rr_next;
    logic                  beat;
    logic                  close_beat;
    logic                  timeout;

    // Lowest offset from rr_ptr wins, so scan from the far end and let nearer hits override.
    // NOTE: every signal driven here gets a default first, otherwise the tool infers latches.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (req_valid[cand[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
    end

    // Grant is one-hot, so an AND-OR mux selects the owner's inputs.
    always_comb begin
        g_idx  = '0;
        g_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_idx  = PW'(i);
                g_data = g_data | req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    assign g_valid    = |(req_valid & grant);
    assign g_last     = |(req_last & grant);
    assign rr_next    = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);

    assign beat       = (state == S_XFER) && g_valid && !tx_full;
    assign close_beat = beat && (g_last || (burst_cnt == BURST_LAST));
    assign timeout    = (state == S_XFER) && !beat && (idle_cnt == IDLE_LAST);

    assign req_ready  = ((state == S_XFER) && !tx_full) ? grant : '0;
    assign wen        = beat;
    assign wr_data    = beat ? g_data : '0;
    assign busy       = (state != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            idle_cnt  <= '0;
            tx_begin  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant     <= NREQ'(1) << pick_idx;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                        state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (beat) begin
                        burst_cnt <= burst_cnt + BW'(1);
                        idle_cnt  <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt  <= idle_cnt + IW'(1);
                    end
                    if (close_beat || timeout) begin
                        rr_ptr <= rr_next;
                        // An empty grant has nothing to send, so skip FLUSH entirely.
                        if (close_beat || (burst_cnt != '0)) begin
                            state    <= S_FLUSH;
                            tx_begin <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            grant <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (tx_done && tx_empty) begin
                        tx_begin <= 1'b0;
                        grant    <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a per-cycle vector table, directed corner cases,
// and randomized client/UART traffic compared against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int W     = 8;
    localparam int MAXB  = 8;
    localparam int IDLET = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0] req_last;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] grant;
    logic            wen;
    logic [W-1:0]    wr_data;
    logic            tx_full;
    logic            tx_empty;
    logic            tx_done;
    logic            tx_begin;
    logic            busy;

    uart_tx_arbiter #(
        .NREQ(NREQ), .FIFO_WIDTH(W), .FIFO_DEPTH(8), .MAX_BURST(MAXB), .IDLE_TIMEOUT(IDLET)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .grant(grant), .wen(wen), .wr_data(wr_data),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_done(tx_done),
        .tx_begin(tx_begin), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- client queues, UART stand-in, traffic knobs ----------------
    logic [8:0] cbuf [NREQ][64];
    int chead [NREQ];
    int ctail [NREQ];
    int  valid_pct, full_pct, u_cnt, cyc_n;
    bit  force_full;
    logic [NREQ-1:0] vmask;

    // ---------------- reference model (transaction level) ----------------
    int m_phase;   // 0 = no owner, 1 = accepting bytes, 2 = waiting for UART to drain
    int m_owner, m_bytes, m_idle, m_rr;

    // observation logs
    int glog[$];
    int blog[$];
    logic [NREQ-1:0] prev_g;
    logic prev_txb;
    int bcount, last_wen_cyc, txb_rise_cyc, total_enq, total_wen;

    task automatic push_byte(input int c, input logic last, input logic [7:0] d);
        cbuf[c][ctail[c]] = {last, d};
        ctail[c]++;
        total_enq++;
    endtask

    task automatic push_frame(input int c, input int len, input bit with_last);
        for (int i = 0; i < len; i++)
            push_byte(c, with_last && (i == len - 1), 8'($urandom));
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_bytes = 0; m_idle = 0; m_rr = 0;
    endtask

    task automatic obs_reset();
        for (int c = 0; c < NREQ; c++) begin chead[c] = 0; ctail[c] = 0; end
        u_cnt = 0; prev_g = '0; prev_txb = 1'b0; bcount = 0;
        glog.delete(); blog.delete();
        last_wen_cyc = -1; txb_rise_cyc = -1; total_enq = 0; total_wen = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_data = '0; req_last = '0;
        tx_full = 1'b0; tx_empty = 1'b1; tx_done = 1'b0;
        repeat (2) @(negedge clk);
        obs_reset();
        model_reset();
        rst = 1'b0;
    endtask

    // One clock of automatic traffic: drive at negedge, check 1 ns later, model the edge.
    task automatic cycle();
        logic [NREQ-1:0] eg, er;
        logic            ew;
        logic [7:0]      ed;
        logic            mbeat, close;
        bit              found;
        int              c;
        @(negedge clk);
        cyc_n++;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (chead[i] < ctail[i]) && ($urandom_range(99) < valid_pct) && vmask[i];
            req_data[i*W +: W] = (chead[i] < ctail[i]) ? cbuf[i][chead[i]][7:0] : 8'h00;
            req_last[i] = (chead[i] < ctail[i]) ? cbuf[i][chead[i]][8] : 1'b0;
        end
        tx_full = force_full || ($urandom_range(99) < full_pct);
        tx_done = 1'b0;
        if (tx_begin && u_cnt > 0 && $urandom_range(3) == 0) begin
            u_cnt--;
            tx_done = 1'b1;
        end
        tx_empty = (u_cnt == 0);
        #1;
        mbeat = (m_phase == 1) && req_valid[m_owner] && !tx_full;
        eg = (m_phase != 0) ? NREQ'(1) << m_owner : '0;
        er = (m_phase == 1 && !tx_full) ? NREQ'(1) << m_owner : '0;
        ew = mbeat;
        ed = mbeat ? req_data[m_owner*W +: W] : 8'h00;
        check("grant", 32'(grant), 32'(eg));
        check("req_ready", 32'(req_ready), 32'(er));
        check("wen", 32'(wen), 32'(ew));
        check("wr_data", 32'(wr_data), 32'(ed));
        check("tx_begin", 32'(tx_begin), 32'(m_phase == 2));
        check("busy", 32'(busy), 32'(m_phase != 0));
        // observation logs and client/UART bookkeeping
        if (grant != '0 && prev_g == '0) begin glog.push_back(onehot_idx(grant)); bcount = 0; end
        if (wen) begin bcount++; total_wen++; last_wen_cyc = cyc_n; u_cnt++; end
        if (grant == '0 && prev_g != '0) blog.push_back(bcount);
        if (tx_begin && !prev_txb) txb_rise_cyc = cyc_n;
        prev_g = grant; prev_txb = tx_begin;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) chead[i]++;
            if (chead[i] == ctail[i]) begin chead[i] = 0; ctail[i] = 0; end
        end
        // model the edge from the arbitration rules
        case (m_phase)
            0: if (req_valid != '0) begin
                found = 0;
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_rr + k) % NREQ;
                    if (!found && req_valid[c]) begin m_owner = c; found = 1; end
                end
                m_bytes = 0; m_idle = 0; m_phase = 1;
            end
            1: begin
                close = 0;
                if (mbeat) begin
                    m_bytes++; m_idle = 0;
                    close = req_last[m_owner] || (m_bytes == MAXB);
                end else begin
                    close = (m_idle == IDLET - 1);
                    m_idle++;
                end
                if (close) begin
                    m_rr = (m_owner + 1) % NREQ;
                    m_phase = (m_bytes > 0) ? 2 : 0;
                end
            end
            default: if (tx_done && tx_empty) m_phase = 0;
        endcase
    endtask

    task automatic run_until_idle(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            cycle();
            done = (m_phase == 0) && !busy;
            for (int c = 0; c < NREQ; c++) if (ctail[c] != 0) done = 0;
        end
        check({name, "_drained"}, 32'(done), 32'd1);
    endtask

    // ---------------- vector table: single client 1 frame 0x3C, 0xA5 ----------------
    typedef struct {
        logic [3:0] v;  logic [7:0] d;  logic l;
        logic full;     logic empty;    logic done;
        logic [3:0] e_grant; logic [3:0] e_ready; logic e_wen; logic [7:0] e_wr;
        logic e_txb;    logic e_busy;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        valid_pct = 100; full_pct = 0; force_full = 0; vmask = '1; cyc_n = 0;
        tbl[0] = '{4'b0010, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{4'b0010, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h3C, 1'b0, 1'b1};
        tbl[2] = '{4'b0010, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'hA5, 1'b0, 1'b1};
        tbl[3] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[6] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};

        do_reset();
        #1;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_tx_begin", 32'(tx_begin), 32'd0);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req_valid = tbl[i].v;
            req_data  = {16'h0000, tbl[i].d, 8'h00};
            req_last  = {2'b00, tbl[i].l, 1'b0};
            tx_full = tbl[i].full; tx_empty = tbl[i].empty; tx_done = tbl[i].done;
            #1;
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
            check($sformatf("vec%0d_wen", i), 32'(wen), 32'(tbl[i].e_wen));
            check($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].e_wr));
            check($sformatf("vec%0d_tx_begin", i), 32'(tx_begin), 32'(tbl[i].e_txb));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
        end

        // Pointer now sits at 2 after serving client 1: client 2 beats client 0.
        obs_reset(); model_reset(); m_rr = 2;
        push_byte(0, 1'b1, 8'h40);
        push_byte(2, 1'b1, 8'h42);
        run_until_idle("rr_after_c1", 300);
        check("rr_order_len", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            check("rr_order0", 32'(glog[0]), 32'd2);
            check("rr_order1", 32'(glog[1]), 32'd0);
        end

        // Contention from reset: clients 0, 2, 3 each with a 1-byte frame.
        do_reset();
        push_byte(0, 1'b1, 8'hA0); push_byte(2, 1'b1, 8'hA2); push_byte(3, 1'b1, 8'hA3);
        run_until_idle("contention", 300);
        check("cont_order_len", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) begin
            check("cont_order0", 32'(glog[0]), 32'd0);
            check("cont_order1", 32'(glog[1]), 32'd2);
            check("cont_order2", 32'(glog[2]), 32'd3);
        end

        // Burst limit: 12 bytes without last split into 8 then 4 (the 4 close by timeout).
        do_reset();
        push_frame(0, 12, 0);
        run_until_idle("max_burst", 600);
        check("burst_grants", 32'(blog.size()), 32'd2);
        if (blog.size() == 2) begin
            check("burst_len0", 32'(blog[0]), 32'd8);
            check("burst_len1", 32'(blog[1]), 32'd4);
        end

        // Backpressure: tx_full for 5 cycles after 2 bytes of a 6-byte frame.
        begin
            int stalls = 0;
            int guard = 0;
            do_reset();
            push_frame(3, 6, 1);
            while (bcount < 2 && guard < 50) begin cycle(); guard++; end
            force_full = 1;
            repeat (5) begin
                cycle();
                if (req_ready == '0 && !wen && grant == 4'b1000) stalls++;
            end
            force_full = 0;
            check("bp_stall_cycles", 32'(stalls), 32'd5);
            run_until_idle("backpressure", 300);
            check("bp_len", 32'(blog.size() == 1 ? blog[0] : -1), 32'd6);
        end

        // Timeout: client 2 sends 3 bytes then goes quiet.
        do_reset();
        push_frame(2, 3, 0);
        run_until_idle("timeout", 400);
        check("timeout_gap", 32'(txb_rise_cyc - last_wen_cyc), 32'd65);
        check("timeout_len", 32'(blog.size() == 1 ? blog[0] : -1), 32'd3);

        // Zero-byte grant: valid only long enough to be granted, then withdrawn.
        begin
            bit saw_txb = 0;
            push_byte(1, 1'b1, 8'h77);
            cycle();
            vmask = '0;
            for (int i = 0; i < 70; i++) begin cycle(); if (tx_begin) saw_txb = 1; end
            check("zero_grant_tx_begin", 32'(saw_txb), 32'd0);
            check("zero_grant_busy", 32'(busy), 32'd0);
            vmask = '1;
            run_until_idle("zero_grant_retry", 300);
            check("zero_grant_total", 32'(total_wen), 32'd4);
        end

        // Reset mid-transfer after 2 of 5 bytes, then pointer must start at 0 again.
        begin
            int guard = 0;
            do_reset();
            push_frame(1, 5, 1);
            while (bcount < 2 && guard < 50) begin cycle(); guard++; end
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("rst_grant", 32'(grant), 32'd0);
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_wen", 32'(wen), 32'd0);
            check("rst_wr_data", 32'(wr_data), 32'd0);
            check("rst_tx_begin", 32'(tx_begin), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            do_reset();
            push_byte(1, 1'b1, 8'h11);
            push_byte(3, 1'b1, 8'h33);
            run_until_idle("post_reset", 300);
            check("post_rst_len", 32'(glog.size()), 32'd2);
            if (glog.size() == 2) begin
                check("post_rst_order0", 32'(glog[0]), 32'd1);
                check("post_rst_order1", 32'(glog[1]), 32'd3);
            end
        end

        // Randomized traffic against the reference model.
        do_reset();
        valid_pct = 80; full_pct = 15;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NREQ; c++)
                if (ctail[c] == 0 && $urandom_range(9) == 0)
                    push_frame(c, $urandom_range(1, 12), $urandom_range(9) < 8);
            cycle();
        end
        valid_pct = 100; full_pct = 0;
        run_until_idle("random", 2000);
        check("random_byte_count", 32'(total_wen), 32'(total_enq));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and transmit sequencer that shares one UART transmit path (TX FIFO write port plus `tx_begin`) among `NREQ` byte-stream clients. It sits between the clients and the `UART` top. It grants one client at a time for a whole frame, or up to `MAX_BURST` bytes. It then starts transmission and holds the grant until the UART has drained, so frames from different clients never interleave on `tx`.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `FIFO_WIDTH`, 8, byte width; must match UART `FIFO_WIDTH`
- `FIFO_DEPTH`, 8, UART TX FIFO depth; informational, `MAX_BURST` ≤ `FIFO_DEPTH`
- `MAX_BURST`, 8, maximum bytes accepted per grant
- `IDLE_TIMEOUT`, 64, clk cycles without a beat before a granted burst is force-closed

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `req_valid`  in  NREQ  client i has a byte
- `req_data`  in  NREQ*FIFO_WIDTH  client i byte in slice [i*FIFO_WIDTH +: FIFO_WIDTH]
- `req_last`  in  NREQ  byte is the last of client i's frame
- `req_ready`  out  NREQ  byte of client i accepted this cycle when valid&ready
- `grant`  out  NREQ  one-hot current owner; all-zero when idle
- `wen`  out  1  UART TX FIFO write enable
- `wr_data`  out  FIFO_WIDTH  UART TX FIFO write data
- `tx_full`  in  1  UART TX FIFO full
- `tx_empty`  in  1  UART TX FIFO empty
- `tx_done`  in  1  UART one-cycle pulse at end of each transmitted character
- `tx_begin`  out  1  UART transmit enable (level)
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, XFER, FLUSH.
- IDLE:
  - If any `req_valid` is high, pick the first set bit searching upward from `rr_ptr` (wrapping modulo NREQ).
  - Register it into `grant`, clear `burst_cnt` and `idle_cnt`, and go to XFER.
- XFER:
  - `req_ready[g] = !tx_full`; all other `req_ready` bits are 0.
  - Beat = `req_valid[g] & req_ready[g]`. On a beat: `wen = 1`, `wr_data = req_data[g]`, `burst_cnt++`, `idle_cnt = 0`.
  - With no beat: `idle_cnt++` (saturating).
  - Close the burst on any of:
    - a beat with `req_last[g]`;
    - a beat with `burst_cnt == MAX_BURST-1`;
    - `idle_cnt == IDLE_TIMEOUT-1` with no beat.
  - On close: go to FLUSH, set `tx_begin`, and set `rr_ptr = g+1` mod NREQ.
  - Timeout with `burst_cnt == 0` (nothing written): go directly to IDLE; `tx_begin` stays 0 and `rr_ptr` still advances.
- FLUSH:
  - `req_ready = 0`, `wen = 0`, `grant` held.
  - When `tx_done & tx_empty`: clear `tx_begin`, clear `grant`, go to IDLE.
- `wen` and `wr_data` are combinational from the handshake.
- Whenever `wen = 0`, `wr_data` is 0.
- `burst_cnt` width: $clog2(MAX_BURST+1).
- `idle_cnt` width: $clog2(IDLE_TIMEOUT+1).
- `rr_ptr` width: $clog2(NREQ).
- Reset at any point (including mid-XFER or FLUSH) forces IDLE.
  - Bytes already in the UART FIFO are left to the UART's own reset.
- `req_valid` falling mid-burst is legal; the burst stays owned until last, MAX_BURST or timeout.
- A late `req_valid` from a non-granted client is ignored until IDLE.

## Timing
- Reset values:
  - `grant`, `req_ready`, `wen`, `wr_data`, `tx_begin`, `busy` = 0
  - `rr_ptr` = 0
  - state = IDLE
- Grant latency: `req_valid` high at edge n in IDLE → `grant` and `busy` high after edge n; first byte can be written in cycle n+1.
- Throughput: 1 byte/clk while `tx_full = 0`.
- `tx_full` rising stalls the same cycle (combinational ready).
- `tx_begin` rises on the edge that samples the closing beat, so it is high from the next cycle.
- `tx_begin` falls on the edge sampling `tx_done & tx_empty`. IDLE is entered in the same cycle, so a new grant is possible one cycle later.
- `tx_done` without `tx_empty` in FLUSH is ignored. `tx_done` in IDLE or XFER is ignored.

## Test plan
- Single client, NREQ=4: client 1 sends 0x3C, 0xA5 (last on 0xA5) → `grant` = 0001_0 (bit1); `wen` pulses 2 cycles with 0x3C, 0xA5; `tx_begin` high from the next cycle until `tx_done & tx_empty`; `rr_ptr` = 2.
- Contention: clients 0, 2 and 3 valid together from reset, each sending a 1-byte frame → grant order 0, 2, 3; no two frames' bytes interleave on `wr_data`.
- MAX_BURST=8: client 0 streams 12 bytes with no last → 8 bytes written, FLUSH; then (client 0 the only requester) regrant, remaining 4 written.
- Backpressure: `tx_full` = 1 for 5 cycles mid-burst → `req_ready` = 0 and `wen` = 0 for exactly those cycles; no byte is lost or duplicated.
- Timeout, IDLE_TIMEOUT=64: client 2 sends 3 bytes then drops valid → FLUSH after 64 idle cycles, `tx_begin` = 1. Separately, a grant with zero bytes written → return to IDLE with `tx_begin` = 0.
- Reset mid-XFER after 2 of 5 bytes → all outputs 0 on the reset edge; after release, client 1 frame 0x11 is granted normally with `rr_ptr` starting at 0.
